// File: rtl/serial_slice_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_slice_pkg
// Description : Shared types and constants for the bit-serial slice adder.
//               SLICE_W is the number of operand bits consumed per accepted
//               cycle; state_t encodes the controller states.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_slice_pkg;

    localparam int SLICE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_slice_pkg
`default_nettype wire

// File: rtl/slice_adder.sv
`default_nettype none
// ============================================================================
// Module      : slice_adder
// Description : Combinational 2-bit ripple adder built from two full adders.
// Ports       : a[1:0], b[1:0], cin -> s[1:0], cout
// Revision    : 1.0 - initial release
// ============================================================================
module slice_adder (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] s,
    output logic       cout
);

    logic w_c0;

    // Bit 0 full adder
    assign s[0] = a[0] ^ b[0] ^ cin;
    assign w_c0 = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);

    // Bit 1 full adder, carry rippled from bit 0
    assign s[1] = a[1] ^ b[1] ^ w_c0;
    assign cout = (a[1] & b[1]) | (a[1] & w_c0) | (b[1] & w_c0);

endmodule : slice_adder
`default_nettype wire

// File: rtl/serial_slice_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_slice_adder
// Description : Bit-serial two's-complement adder/subtractor. Takes one 2-bit
//               slice of A and B per accepted cycle (LSB slice first), chains
//               the carry through a flop and shifts result slices in from the
//               top so the first slice lands in sum[1:0].
// Ports       : clk, rst (async, active-high)
//               start, sub          - begin operation / 1 = A-B
//               in_valid, in_ready  - slice handshake (a_slice, b_slice)
//               busy, done          - RUN indicator / one-cycle result pulse
//               sum, cout           - held result and final carry
// Revision    : 1.0 - initial release
// ============================================================================
module serial_slice_adder
    import serial_slice_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             in_valid,
    input  logic [1:0]       a_slice,
    input  logic [1:0]       b_slice,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int c_NUM_SLICES = WIDTH / SLICE_W;
    localparam int c_CNT_W      = (c_NUM_SLICES > 1) ? $clog2(c_NUM_SLICES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(c_NUM_SLICES - 1);

    state_t             r_state;
    logic               r_sub;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_done;

    logic [1:0]         w_b;
    logic [1:0]         w_s;
    logic               w_c;
    logic               w_start_accept;

    // Subtraction is A + ~B + 1: invert B here, the +1 comes from the
    // carry flop being preset to 1 on start.
    assign w_b = r_sub ? ~b_slice : b_slice;

    // Start is only honoured while not running; in RUN it is ignored.
    assign w_start_accept = start && ((r_state == IDLE) || (r_state == DONE));

    slice_adder u_slice_adder (
        .a    (a_slice),
        .b    (w_b),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sub      <= 1'b0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_accept) begin
                r_state    <= RUN;
                r_sub      <= sub;
                r_carry    <= sub;
                r_cnt      <= '0;
                r_sum      <= '0;
                r_in_ready <= 1'b1;
                r_busy     <= 1'b1;
            end else begin
                case (r_state)
                    RUN: begin
                        if (in_valid) begin
                            r_carry <= w_c;
                            r_sum   <= {w_s, r_sum[WIDTH-1:SLICE_W]};
                            r_cnt   <= r_cnt + 1'b1;
                            if (r_cnt == c_LAST_CNT) begin
                                r_state    <= DONE;
                                r_cout     <= w_c;
                                r_done     <= 1'b1;
                                r_in_ready <= 1'b0;
                                r_busy     <= 1'b0;
                            end
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state    <= IDLE;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;

endmodule : serial_slice_adder
`default_nettype wire

// File: tb/tb_serial_slice_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_slice_adder
// Description : Self-checking bench for serial_slice_adder. Expected results
//               come from whole-word arithmetic on the operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_slice_adder;

    localparam int WIDTH   = 8;
    localparam int NSLICES = WIDTH / 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic             in_valid;
    logic [1:0]       a_slice;
    logic [1:0]       b_slice;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_cmp;
    int n_err;

    logic [WIDTH-1:0] last_sum;
    logic             last_cout;

    serial_slice_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .in_valid (in_valid),
        .a_slice  (a_slice),
        .b_slice  (b_slice),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Non-running cycles: in_valid/slices toggle freely and must have no effect.
    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            start    = 1'b0;
            in_valid = 1'($urandom);
            a_slice  = 2'($urandom);
            b_slice  = 2'($urandom);
            @(negedge clk);
            check("idle_busy",  32'(busy), 32'd0);
            check("idle_ready", 32'(in_ready), 32'd0);
            check("idle_done",  32'(done), 32'd0);
            check("idle_sum",   32'(sum), 32'(last_sum));
            check("idle_cout",  32'(cout), 32'(last_cout));
        end
        in_valid = 1'b0;
    endtask

    // One full operation. Starts at a negedge (IDLE or DONE), returns at the
    // negedge of the DONE cycle so a following call is back-to-back.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s, input int stall_lo, input int stall_hi,
                          input bit noise);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] bop;
        int               stalls;
        bop  = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bop} + (WIDTH+1)'(s);

        start    = 1'b1;
        sub      = s;
        in_valid = noise ? 1'($urandom) : 1'b0;
        a_slice  = 2'($urandom);
        b_slice  = 2'($urandom);
        @(negedge clk);
        start = 1'b0;
        if (noise) sub = 1'($urandom);
        check("run_busy",  32'(busy), 32'd1);
        check("run_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < NSLICES; i++) begin
            stalls = $urandom_range(stall_hi, stall_lo);
            for (int k = 0; k < stalls; k++) begin
                in_valid = 1'b0;
                a_slice  = 2'($urandom);
                b_slice  = 2'($urandom);
                start    = noise ? 1'($urandom) : 1'b0;
                @(negedge clk);
                check("stall_busy", 32'(busy), 32'd1);
                check("stall_done", 32'(done), 32'd0);
            end
            in_valid = 1'b1;
            a_slice  = a[2*i +: 2];
            b_slice  = b[2*i +: 2];
            start    = noise ? 1'($urandom) : 1'b0;
            @(negedge clk);
            if (i < NSLICES - 1) begin
                check("mid_busy", 32'(busy), 32'd1);
                check("mid_done", 32'(done), 32'd0);
            end
        end

        start    = 1'b0;
        in_valid = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy",  32'(busy), 32'd0);
        check("done_ready", 32'(in_ready), 32'd0);
        check("sum",        32'(sum), 32'(full[WIDTH-1:0]));
        check("cout",       32'(cout), 32'(full[WIDTH]));
        last_sum  = full[WIDTH-1:0];
        last_cout = full[WIDTH];
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        last_sum  = '0;
        last_cout = 1'b0;
        rst       = 1'b1;
        start     = 1'b0;
        sub       = 1'b0;
        in_valid  = 1'b0;
        a_slice   = 2'd0;
        b_slice   = 2'd0;

        repeat (2) @(negedge clk);
        check("rst_sum",   32'(sum), 32'd0);
        check("rst_cout",  32'(cout), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        idle_cycles(2);

        // Directed cases
        run_op(8'hB7, 8'h5C, 1'b0, 0, 0, 1'b0);
        check("add_b7_5c", 32'(sum), 32'h13);
        idle_cycles(2);
        run_op(8'h50, 8'h30, 1'b1, 0, 0, 1'b0);
        idle_cycles(1);
        run_op(8'h30, 8'h50, 1'b1, 0, 0, 1'b0);
        idle_cycles(1);
        run_op(8'hB7, 8'h5C, 1'b0, 3, 3, 1'b0);
        idle_cycles(1);

        // Back-to-back: second start issued in the DONE cycle
        run_op(8'hB7, 8'h5C, 1'b0, 0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 0, 1'b0);
        idle_cycles(1);

        // Reset after two accepted slices
        start = 1'b1; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a_slice  = 2'd3;
            b_slice  = 2'd1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mrst_sum",   32'(sum), 32'd0);
        check("mrst_cout",  32'(cout), 32'd0);
        check("mrst_done",  32'(done), 32'd0);
        check("mrst_busy",  32'(busy), 32'd0);
        check("mrst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        last_sum  = '0;
        last_cout = 1'b0;
        idle_cycles(1);
        run_op(8'h12, 8'h34, 1'b0, 0, 0, 1'b0);
        idle_cycles(2);

        // Ignored start pulses in RUN and in_valid noise outside RUN
        run_op(8'hB7, 8'h5C, 1'b0, 0, 2, 1'b1);
        idle_cycles(2);

        // Randomized operations, random stalls, gaps and noise
        for (int n = 0; n < 60; n++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0, 2, 1'($urandom));
            idle_cycles($urandom_range(2, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_slice_adder
`default_nettype wire
